fwft_sync_fifo: RTL and testbench

Next-generation synchronous FIFO with first-word-fall-through behaviour and valid/ready handshakes on both sides.
- Storage is an internal register array, with no separate RAM instance.
- Depth can be any value ≥2, not only powers of two.
- Adds fill-level reporting, programmable almost-full/almost-empty flags, synchronous flush and a high-watermark monitor.
- Sits between any producer/consumer pair in the datapath where buffering and occupancy visibility are needed.

---
 rtl/fwft_sync_fifo.sv | 161 ++++++++++++++++
 tb/tb_fwft_sync_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_sync_fifo.sv
// fwft_sync_fifo: synchronous first-word-fall-through FIFO, register-array storage,
// valid/ready handshakes on both sides, any depth >= 2 (non-power-of-2 allowed).
// Adds occupancy reporting, almost-full/almost-empty flags, synchronous flush and a
// high-watermark monitor.
//
// Optional build macro: FIFO_BYPASS_EN
//   When defined, a word offered to an empty FIFO appears on the pop side in the same
//   cycle; if it is taken that cycle it never touches storage.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   flush_i        synchronous clear of contents (watermark unaffected)
//   push_data_i    write payload
//   push_valid_i   producer offers push_data_i
//   push_ready_o   FIFO accepts a word this cycle
//   pop_data_o     head-of-queue payload (0 when pop_valid_o is low)
//   pop_valid_o    pop_data_o is valid
//   pop_ready_i    consumer takes pop_data_o this cycle
//   level_o        registered occupancy, 0..FIFO_DEPTH
//   almost_full_o  level_o >= AF_THRESH
//   almost_empty_o level_o <= AE_THRESH
//   hwm_o          highest occupancy since reset or last watermark clear
//   hwm_clr_i      reload the watermark with the next occupancy value
module fwft_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
    parameter int unsigned AE_THRESH  = 1,
    parameter int unsigned LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [LW-1:0]         level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [LW-1:0]         hwm_o,
    input  logic                  hwm_clr_i
);

    localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] hwm_q, hwm_d;

    logic push_hs;
    logic pop_hs;
    logic wr_en;
    logic rd_en;
    logic empty;

    assign empty = (level_q == '0);

    // Ready depends only on registered state plus flush, so a pop in a full cycle
    // never enables a write-through.
    assign push_ready_o = !flush_i && (level_q != LVL_FULL);

`ifdef FIFO_BYPASS_EN
    logic bypass;

    always_comb begin
        if (empty) begin
            pop_valid_o = push_valid_i && !flush_i;
            pop_data_o  = pop_valid_o ? push_data_i : '0;
        end else begin
            pop_valid_o = !flush_i;
            pop_data_o  = pop_valid_o ? mem[rd_ptr_q] : '0;
        end
    end

    assign push_hs = push_valid_i && push_ready_o;
    assign pop_hs  = pop_valid_o && pop_ready_i;
    // A word taken in the same cycle it is offered to an empty FIFO skips storage.
    assign bypass  = empty && push_hs && pop_hs;
    assign wr_en   = push_hs && !bypass;
    assign rd_en   = pop_hs && !bypass;
`else
    always_comb begin
        pop_valid_o = !flush_i && !empty;
        pop_data_o  = pop_valid_o ? mem[rd_ptr_q] : '0;
    end

    assign push_hs = push_valid_i && push_ready_o;
    assign pop_hs  = pop_valid_o && pop_ready_i;
    assign wr_en   = push_hs;
    assign rd_en   = pop_hs;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            if (wr_en && !rd_en) begin
                level_d = level_q + LW'(1);
            end else if (rd_en && !wr_en) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    // Watermark tracks the occupancy being loaded this cycle, not the current one.
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr_i) begin
            hwm_d = level_d;
        end else if (level_d > hwm_q) begin
            hwm_d = level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hwm_q    <= hwm_d;
        end
    end

    // Storage is intentionally not reset; level gating keeps stale words hidden.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    assign level_o        = level_q;
    assign hwm_o          = hwm_q;
    assign almost_full_o  = (level_q >= LW'(AF_THRESH));
    assign almost_empty_o = (level_q <= LW'(AE_THRESH));

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// tb_fwft_sync_fifo: directed bench for fwft_sync_fifo (DEPTH=4, AF=3, AE=1, 8-bit data).
// Stimulus tasks push expected words into a scoreboard queue; a separate negedge monitor
// pops and compares whenever the DUT completes a pop handshake.
module tb_fwft_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic [DW-1:0] push_data_i;
    logic          push_valid_i;
    logic          push_ready_o;
    logic [DW-1:0] pop_data_o;
    logic          pop_valid_o;
    logic          pop_ready_i;
    logic [LW-1:0] level_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic [LW-1:0] hwm_o;
    logic          hwm_clr_i;

    fwft_sync_fifo #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .push_data_i   (push_data_i),
        .push_valid_i  (push_valid_i),
        .push_ready_o  (push_ready_o),
        .pop_data_o    (pop_data_o),
        .pop_valid_o   (pop_valid_o),
        .pop_ready_i   (pop_ready_i),
        .level_o       (level_o),
        .almost_full_o (almost_full_o),
        .almost_empty_o(almost_empty_o),
        .hwm_o         (hwm_o),
        .hwm_clr_i     (hwm_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    int          m_level = 0;
    int          m_hwm   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every completed pop must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && pop_valid_o && pop_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon_unexpected_pop: got %02h, expected no pop", pop_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("mon_data", pop_data_o, mon_exp);
            end
        end
    end

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input logic pv, input logic [7:0] pd, input logic pr,
                       input logic fl, input logic hc, input string tag);
        logic e_pr, e_pv, acc, pop;
        int   nxt;
        push_valid_i = pv;
        push_data_i  = pd;
        pop_ready_i  = pr;
        flush_i      = fl;
        hwm_clr_i    = hc;
        e_pr = !fl && (m_level != DEPTH);
        e_pv = !fl && ((m_level != 0) || (BYP && pv));
        acc  = pv && e_pr;
        pop  = e_pv && pr;
        if (acc) exp_q.push_back(pd);
        @(negedge clk);
        check({tag, ":push_ready"}, push_ready_o, e_pr);
        check({tag, ":pop_valid"}, pop_valid_o, e_pv);
        check({tag, ":level"}, level_o, m_level);
        check({tag, ":almost_full"}, almost_full_o, m_level >= AF);
        check({tag, ":almost_empty"}, almost_empty_o, m_level <= AE);
        check({tag, ":hwm"}, hwm_o, m_hwm);
        if (!e_pv) check({tag, ":pop_data_zero"}, pop_data_o, 0);
        nxt = fl ? 0 : m_level + int'(acc) - int'(pop);
        m_hwm   = hc ? nxt : ((nxt > m_hwm) ? nxt : m_hwm);
        m_level = nxt;
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":level"}, level_o, 0);
        check({tag, ":hwm"}, hwm_o, 0);
        check({tag, ":push_ready"}, push_ready_o, 1);
        check({tag, ":pop_valid"}, pop_valid_o, 0);
        check({tag, ":pop_data"}, pop_data_o, 0);
        check({tag, ":almost_empty"}, almost_empty_o, 1);
        check({tag, ":almost_full"}, almost_full_o, 0);
    endtask

    logic [7:0] fill_vals [4];

    initial begin
        fill_vals[0] = 8'h11;
        fill_vals[1] = 8'h22;
        fill_vals[2] = 8'h33;
        fill_vals[3] = 8'h44;
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        push_data_i  = '0;
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        hwm_clr_i    = 1'b0;
        #12;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill then drain.
        for (int i = 0; i < 4; i++) cyc(1'b1, fill_vals[i], 1'b0, 1'b0, 1'b0, "fill");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "full_idle");
        check("fill:level4", level_o, 4);
        check("fill:ready_low", push_ready_o, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "empty_idle");
        check("drain:level0", level_o, 0);
        check("drain:almost_empty", almost_empty_o, 1);

        // Full with simultaneous push and pop: only the pop happens.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, "fill2");
        cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "full_pushpop");
        check("full_pushpop:level3", level_o, 3);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, "full_retry");
        check("full_retry:level4", level_o, 4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain2");

        // Wrap-around streaming, level steady at 1.
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "stream_first");
        for (int i = 1; i < 20; i++) cyc(1'b1, 8'(i * 7), 1'b1, 1'b0, 1'b0, "stream");
        check("stream:level1", level_o, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "stream_last");

        // Watermark: reach 4, drain to 1, clear.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, "wm_fill");
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "wm_drain");
        check("wm:hwm_before_clear", hwm_o, 4);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "wm_clr");
        check("wm:hwm_after_clear", hwm_o, 1);

        // Flush at level 3 with a push pending.
        cyc(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0, "pre_flush");
        cyc(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0, "pre_flush");
        check("pre_flush:hwm3", hwm_o, 3);
        cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, "flush");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "post_flush");
        check("post_flush:level0", level_o, 0);
        check("post_flush:hwm3", hwm_o, 3);

        // Reset mid-operation at level 2.
        cyc(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, "pre_rst");
        cyc(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0, "pre_rst");
        push_valid_i = 1'b0;
        check("pre_rst:level2", level_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        exp_q.delete();
        m_level = 0;
        m_hwm   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "after_rst");

`ifdef FIFO_BYPASS_EN
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, "bypass_through");
        check("bypass:level0", level_o, 0);
        cyc(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0, "bypass_hold");
        check("bypass_hold:level1", level_o, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "bypass_pop");
`else
        // No same-cycle path: a word offered to an empty FIFO appears one cycle later.
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, "fwft_push");
        check("fwft:level1", level_o, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "fwft_pop");
`endif
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "final_idle");
        check("final:scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
